pipelined_mul: RTL and testbench

PIPELINED_MUL -- requirements
Module: pipelined_mul

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_pp8.sv | 8 +
 rtl/pipelined_mul.sv | 115 +++++++++++
 tb/tb_pipelined_mul.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: operation encodings, pipeline depth limits and operand signedness helpers for pipelined_mul.
package mul_pkg;
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } op_e;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  function automatic logic src1_signed(input op_e op);
    return op != MULHU;
  endfunction
  function automatic logic src2_signed(input op_e op);
    return op == MUL || op == MULH;
  endfunction
endpackage

// File: rtl/mul_pp8.sv
// mul_pp8: combinational 8x8 unsigned partial-product multiplier.
module mul_pp8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

// File: rtl/pipelined_mul.sv
// pipelined_mul: STAGES-deep signed/unsigned multiplier with valid/ready flow control and flush.
module pipelined_mul
  import mul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic [1:0]         op,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int N    = WIDTH / 8;
  localparam int NT   = N * N;
  localparam int PW   = 2 * WIDTH;
  localparam int LAST = STAGES - 1;
  logic [STAGES-1:0] v;
  op_e               op_q  [STAGES];
  logic              neg_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic              advance;
  logic              sign1, sign2;
  logic [WIDTH-1:0]  mag1, mag2;
  logic [NT*16-1:0]  pp_d, pp_q;
  logic [PW-1:0]     product_q;
  // Carry-save accumulate partial products lo..hi-1 onto {s_in, c_in}; returns {sum, carry}.
  function automatic logic [2*PW-1:0] csa(input logic [NT*16-1:0] pp, input int lo, input int hi,
                                          input logic [PW-1:0] s_in, input logic [PW-1:0] c_in);
    logic [PW-1:0] s, c, t, s_n;
    s = s_in;
    c = c_in;
    for (int k = 0; k < NT; k++) begin
      if (k >= lo && k < hi) begin
        t   = PW'(pp[k*16 +: 16]) << (8 * (k / N + k % N));
        s_n = s ^ c ^ t;
        c   = ((s & c) | (s & t) | (c & t)) << 1;
        s   = s_n;
      end
    end
    return {s, c};
  endfunction
  function automatic logic [PW-1:0] fin(input logic [2*PW-1:0] sc, input logic neg);
    logic [PW-1:0] m;
    m = sc[2*PW-1:PW] + sc[PW-1:0];
    return neg ? -m : m;
  endfunction
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = v[LAST];
  assign sign1     = src1_signed(op_e'(op)) & src1[WIDTH-1];
  assign sign2     = src2_signed(op_e'(op)) & src2[WIDTH-1];
  assign mag1      = sign1 ? -src1 : src1;
  assign mag2      = sign2 ? -src2 : src2;
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      mul_pp8 u_pp (
        .a(mag1[8*i +: 8]),
        .b(mag2[8*j +: 8]),
        .p(pp_d[16*(i*N+j) +: 16])
      );
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else if (flush) v <= '0;
    else if (advance) v <= {v[STAGES-2:0], in_valid};
  always_ff @(posedge clk)
    if (advance) begin
      op_q[0]  <= op_e'(op);
      neg_q[0] <= sign1 ^ sign2;
      tag_q[0] <= in_tag;
      pp_q     <= pp_d;
      for (int k = 1; k < STAGES; k++) begin
        op_q[k]  <= op_q[k-1];
        neg_q[k] <= neg_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  // Reduction is spread over whatever middle stages the chosen depth provides.
  if (STAGES == STAGES_MIN) begin : g_s2
    always_ff @(posedge clk)
      if (advance) product_q <= fin(csa(pp_q, 0, NT, '0, '0), neg_q[0]);
  end else if (STAGES < STAGES_MAX) begin : g_s3
    logic [2*PW-1:0] sc_q;
    always_ff @(posedge clk)
      if (advance) begin
        sc_q      <= csa(pp_q, 0, NT, '0, '0);
        product_q <= fin(sc_q, neg_q[1]);
      end
  end else begin : g_s4
    logic [2*PW-1:0]  sc1_q, sc2_q;
    logic [NT*16-1:0] pp2_q;
    always_ff @(posedge clk)
      if (advance) begin
        sc1_q     <= csa(pp_q, 0, NT / 2, '0, '0);
        pp2_q     <= pp_q;
        sc2_q     <= csa(pp2_q, NT / 2, NT, sc1_q[2*PW-1:PW], sc1_q[PW-1:0]);
        product_q <= fin(sc2_q, neg_q[2]);
      end
  end
  assign product = product_q;
  assign result  = op_q[LAST] == MUL ? product_q[WIDTH-1:0] : product_q[PW-1:WIDTH];
  assign out_tag = tag_q[LAST];
endmodule

// File: tb/tb_pipelined_mul.sv
// tb_pipelined_mul: table vectors plus stall, flush and reset sequences, all backed by a scoreboard.
module tb_pipelined_mul;
  localparam int W = 32;
  localparam int S = 3;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [63:0] p;
  } vec_t;
  typedef struct {
    logic [31:0] r;
    logic [63:0] p;
    logic [4:0]  tag;
  } exp_t;
  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic [1:0]    op = '0;
  logic [4:0]    in_tag = '0;
  logic          flush = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [W-1:0]  result;
  logic [2*W-1:0] product;
  logic [4:0]    out_tag;
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_pop = 0;
  exp_t          sb[$];
  vec_t          tbl[10];

  pipelined_mul #(.WIDTH(W), .STAGES(S), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .op(op), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .product(product), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] t);
    logic [127:0] x, y, z;
    exp_t e;
    x = {{96{(o != 2'b11) & a[31]}}, a};
    y = {{96{(o == 2'b00 || o == 2'b01) & b[31]}}, b};
    z = x * y;
    e.p = z[63:0];
    e.r = (o == 2'b00) ? z[31:0] : z[63:32];
    e.tag = t;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || flush) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_unexpected_output", {59'd0, out_tag}, 64'hDEAD);
        else begin
          exp_t e;
          e = sb.pop_front();
          n_pop++;
          check("sb_result", {32'd0, result}, {32'd0, e.r});
          check("sb_product", product, e.p);
          check("sb_tag", {59'd0, out_tag}, {59'd0, e.tag});
        end
      end
      if (in_valid && in_ready) sb.push_back(model(op, src1, src2, in_tag));
    end
  end

  always @(negedge rst_n) sb.delete();

  task automatic run_one(input vec_t v, input logic [4:0] t, input string nm);
    int cnt = 0;
    op = v.op; src1 = v.a; src2 = v.b; in_tag = t; in_valid = 1;
    do begin
      @(posedge clk); #1;
      cnt++;
      in_valid = 0;
    end while (!out_valid && cnt < 20);
    check({nm, "_latency"}, 64'(cnt), 64'(S));
    check({nm, "_result"}, {32'd0, result}, {32'd0, v.r});
    check({nm, "_product"}, product, v.p);
    check({nm, "_tag"}, {59'd0, out_tag}, {59'd0, t});
  endtask

  initial begin
    logic [1:0]  s_op[8];
    logic [31:0] s_a[8], s_b[8];
    int sent, p0;
    tbl[0] = '{2'b00, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 64'hFFFFFFFFFFFFFFEB};
    tbl[1] = '{2'b01, 32'h80000000,   32'h80000000, 32'h40000000, 64'h4000000000000000};
    tbl[2] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001};
    tbl[3] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE00000001};
    tbl[4] = '{2'b00, 32'd0,          32'h12345678, 32'h00000000, 64'h0000000000000000};
    tbl[5] = '{2'b01, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 64'h3FFFFFFF00000001};
    tbl[6] = '{2'b01, 32'h80000000,   32'h7FFFFFFF, 32'hC0000000, 64'hC000000080000000};
    tbl[7] = '{2'b00, 32'h12345678,   32'h00000010, 32'h23456780, 64'h0000000123456780};
    tbl[8] = '{2'b10, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 64'h8000000080000000};
    tbl[9] = '{2'b11, 32'h80000000,   32'h00000002, 32'h00000001, 64'h0000000100000000};
    #12;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    #10 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) run_one(tbl[i], 5'(i), $sformatf("vec%0d", i));
    for (int i = 0; i < 8; i++) begin
      s_op[i] = 2'(i);
      s_a[i] = (i == 2) ? 32'h80000000 : $urandom;
      s_b[i] = (i == 5) ? 32'hFFFFFFFF : $urandom;
    end
    @(posedge clk); #1;
    sent = 0;
    p0 = n_pop;
    for (int t = 0; t < 40; t++) begin
      out_ready = !(t >= 5 && t < 9);
      in_valid = sent < 8;
      if (sent < 8) begin
        op = s_op[sent]; src1 = s_a[sent]; src2 = s_b[sent]; in_tag = 5'(16 + sent);
      end
      @(negedge clk);
      if (!out_ready) check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      if (sent == 8 && sb.size() == 0 && t > 9) break;
    end
    in_valid = 0;
    out_ready = 1;
    check("stream_sent", 64'(sent), 64'd8);
    check("stream_received", 64'(n_pop - p0), 64'd8);
    check("stream_drained", 64'(sb.size()), 64'd0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      op = tbl[i].op; src1 = tbl[i].a; src2 = tbl[i].b; in_tag = 5'(i); in_valid = 1;
      @(posedge clk); #1;
    end
    check("flush_pre_valid", {63'd0, out_valid}, 64'd1);
    op = tbl[4].op; src1 = tbl[4].a; src2 = tbl[4].b; in_valid = 1; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < S + 1; i++) begin
      check($sformatf("flush_out_valid_%0d", i), {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    run_one(tbl[5], 5'd9, "post_flush");
    @(posedge clk); #1;
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      op = tbl[6+i].op; src1 = tbl[6+i].a; src2 = tbl[6+i].b; in_tag = 5'(i); in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #1;
    check("rst_pre_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 0;
    #1;
    check("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_async_in_ready", {63'd0, in_ready}, 64'd1);
    #3 rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < S + 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_quiet_%0d", i), {63'd0, out_valid}, 64'd0);
    end
    run_one(tbl[3], 5'd30, "post_rst");
    @(posedge clk); #1;
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
